// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//
// Sequential read-out engine for the register file. A start pulse walks the
// register indices 0..NUM_REGS-1 through one register-file read port. Each
// value is captured into an output holding register and streamed out as an
// (index, data) word on a valid/ready interface. The block is a debug and
// verification channel that sits beside the datapath.
//
// Parameters
//   NUM_REGS  number of registers dumped (indices 0..NUM_REGS-1)
//   ADDR_W    register index width, NUM_REGS <= 2**ADDR_W
//   DATA_W    register data width
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   start      begin a dump; only looked at while idle
//   abort      synchronous cancel; honoured only while a dump is in progress
//   rd_addr    register-file read address (0 while idle)
//   rd_data    register-file read data, combinational from rd_addr
//   out_valid  output word valid
//   out_ready  downstream accepts the current word
//   out_index  register index of the current word
//   out_data   captured register value of the current word
//   out_last   current word is index NUM_REGS-1
//   busy       dump in progress
//   done       one-cycle pulse after the final word has been accepted
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic handshake;
    logic idx_is_last;

    assign handshake   = out_valid_q && out_ready;
    assign idx_is_last = (idx_q == LAST_IDX);

    // State and output holding registers. Everything clears straight away on
    // rst so a dump interrupted by reset leaves no word and no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. Abort is checked before the handshake in the busy
    // states so a cancel arriving with the acceptance of a word wins and no
    // done pulse is produced. The captured word fields are only reloaded in
    // FETCH, which keeps them stable for as long as SEND is back-pressured.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                idx_d       = '0;
                if (start) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    out_data_d  = rd_data;
                    out_index_d = idx_q;
                    out_last_d  = idx_is_last;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_IDLE;
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                idx_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // The read address is parked at 0 while idle so the register file sees a
    // quiet port whenever no dump is running.
    always_comb begin
        rd_addr = '0;
        if (state_q != ST_IDLE) begin
            rd_addr = idx_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
//
// Self-checking bench for regfile_dump. A behavioural register file answers
// the read port. A table of dump scenarios (backpressure, duplicate start,
// register writes during the dump, abort, start+abort together) drives full
// dumps. Expected words are queued when a dump is started and popped by a
// monitor as words are accepted. Hand-written sequences cover the reset
// state, abort while idle and an asynchronous reset in the middle of a dump.
// -----------------------------------------------------------------------------
module tb_regfile_dump;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic [ADDR_W-1:0] out_index;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] regs [NUM_REGS];

   int checks    = 0;
   int errors    = 0;
   int edgeNum   = 0;
   int wordsSeen = 0;
   int doneCount = 0;

   typedef struct {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t expQ[$];

   typedef struct {
      string       name;
      int          bpIdx;
      int          bpLen;
      int          dupIdx;
      int          abortIdx;
      int          wrTrig;
      int          wrAddr;
      logic [31:0] wrData;
      bit          startAbort;
      int          expWords;
      int          expDoneRel;
   } vec_t;

   vec_t vecs [8];

   regfile_dump #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   // Register file model, combinational read
   assign rd_data = regs[rd_addr];

   // Clock generation
   always #5 clk = ~clk;

   // Rising-edge counter used to time done relative to the start edge
   always @(posedge clk) edgeNum <= edgeNum + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every accepted word is compared against the head of the
   // scoreboard; done pulses are counted and must never overlap valid.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            doneCount++;
            checkOutput("done_without_valid", 64'(out_valid), 64'(0));
         end
         if (out_valid && out_ready && !abort) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_word", 64'(out_index), 64'hFFFF);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("word_index", 64'(out_index), 64'(e.idx));
               checkOutput("word_data",  64'(out_data),  64'(e.data));
               checkOutput("word_last",  64'(out_last),  64'(e.last));
               wordsSeen++;
            end
         end
      end
   end

   task automatic presetRegs();
      for (int i = 0; i < NUM_REGS; i++) begin
         regs[i] = (i == 0) ? 32'h0 : (32'hA500_0000 + 32'(i));
      end
   endtask

   function automatic logic [DATA_W-1:0] expectedData(input vec_t v, input int i);
      logic [DATA_W-1:0] base;
      base = (i == 0) ? 32'h0 : (32'hA500_0000 + 32'(i));
      // A write issued while word wrTrig is in SEND is seen only by later fetches
      if (v.wrTrig >= 0 && i == v.wrAddr && v.wrAddr > v.wrTrig) begin
         return v.wrData;
      end
      return base;
   endfunction

   task automatic pushExpected(input vec_t v);
      exp_t e;
      expQ.delete();
      for (int i = 0; i < NUM_REGS; i++) begin
         e.idx  = ADDR_W'(i);
         e.data = expectedData(v, i);
         e.last = (i == NUM_REGS - 1);
         expQ.push_back(e);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      int  e0;
      int  doneRel;
      int  holdLeft;
      bit  busyOk;
      bit  dupDone;
      bit  wrDone;
      bit  abortArmed;
      bit  aborted;

      $display("[TB] scenario %s", v.name);
      presetRegs();
      pushExpected(v);
      wordsSeen  = 0;
      doneCount  = 0;
      doneRel    = -1;
      holdLeft   = v.bpLen;
      busyOk     = 1'b1;
      dupDone    = 1'b0;
      wrDone     = 1'b0;
      abortArmed = 1'b0;
      aborted    = 1'b0;

      @(posedge clk); #1;
      start     = 1'b1;
      abort     = v.startAbort;
      out_ready = 1'b1;
      e0        = edgeNum + 1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      checkOutput({v.name, "_busy_after_start"}, 64'(busy), 64'(1));
      checkOutput({v.name, "_fetch_not_valid"},  64'(out_valid), 64'(0));

      for (int cyc = 0; cyc < 300; cyc++) begin
         if (done) begin
            doneRel = edgeNum - e0;
            break;
         end
         if (!busy) busyOk = 1'b0;
         out_ready = 1'b1;
         start     = 1'b0;
         abort     = 1'b0;
         if (out_valid) begin
            if (int'(out_index) == v.bpIdx && holdLeft > 0) begin
               out_ready = 1'b0;
               holdLeft--;
               checkOutput({v.name, "_hold_index"}, 64'(out_index), 64'(v.bpIdx));
               checkOutput({v.name, "_hold_data"}, 64'(out_data),
                           64'(expectedData(v, v.bpIdx)));
            end
            if (int'(out_index) == v.dupIdx && !dupDone) begin
               start   = 1'b1;
               dupDone = 1'b1;
            end
            if (int'(out_index) == v.wrTrig && !wrDone) begin
               regs[v.wrAddr] = v.wrData;
               wrDone = 1'b1;
            end
            if (int'(out_index) == v.abortIdx) begin
               abort      = 1'b1;
               abortArmed = 1'b1;
            end
         end
         @(posedge clk); #1;
         if (abortArmed) begin
            abort   = 1'b0;
            aborted = 1'b1;
            checkOutput({v.name, "_abort_valid"}, 64'(out_valid), 64'(0));
            checkOutput({v.name, "_abort_busy"},  64'(busy),      64'(0));
            checkOutput({v.name, "_abort_done"},  64'(done),      64'(0));
            break;
         end
      end
      start = 1'b0;
      abort = 1'b0;

      if (aborted) begin
         repeat (4) @(posedge clk);
         #1;
         checkOutput({v.name, "_no_done_after_abort"}, 64'(doneCount), 64'(0));
         checkOutput({v.name, "_idle_after_abort"}, 64'(busy), 64'(0));
         checkOutput({v.name, "_words"}, 64'(wordsSeen), 64'(v.expWords));
         expQ.delete();
      end else begin
         checkOutput({v.name, "_done_edge"}, 64'(doneRel), 64'(v.expDoneRel));
         checkOutput({v.name, "_busy_span"}, 64'(busyOk), 64'(1));
         checkOutput({v.name, "_busy_at_done"}, 64'(busy), 64'(0));
         repeat (2) @(posedge clk);
         #1;
         checkOutput({v.name, "_done_pulses"}, 64'(doneCount), 64'(1));
         checkOutput({v.name, "_words"}, 64'(wordsSeen), 64'(v.expWords));
         checkOutput({v.name, "_queue_empty"}, 64'(expQ.size()), 64'(0));
         expQ.delete();
      end
   endtask

   // Asynchronous reset in the middle of a dump while index 15 is in SEND
   task automatic asyncResetSequence();
      vec_t v;
      bit   found;
      v = '{"async_rst", -1, 0, -1, -1, -1, 0, 32'h0, 1'b0, 15, -1};
      $display("[TB] scenario %s", v.name);
      presetRegs();
      pushExpected(v);
      wordsSeen = 0;
      doneCount = 0;
      found     = 1'b0;
      @(posedge clk); #1;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (out_valid && out_index == 5'd15) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput("rst_reach_idx15", 64'(found), 64'(1));
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_rd_addr",   64'(rd_addr),   64'(0));
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_out_index", 64'(out_index), 64'(0));
      checkOutput("rst_out_data",  64'(out_data),  64'(0));
      checkOutput("rst_out_last",  64'(out_last),  64'(0));
      checkOutput("rst_busy",      64'(busy),      64'(0));
      checkOutput("rst_done",      64'(done),      64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
      checkOutput("rst_words_before", 64'(wordsSeen), 64'(15));
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rst_hold_idle_busy",  64'(busy),      64'(0));
      checkOutput("rst_hold_idle_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_hold_idle_addr",  64'(rd_addr),   64'(0));
      checkOutput("rst_no_done",         64'(doneCount), 64'(0));
   endtask

   initial begin
      //            name          bp  len dup abt wrT wrA wrData        sA words doneRel
      vecs[0] = '{"basic",        -1, 0, -1, -1, -1,  0, 32'h0,        1'b0, 32, 64};
      vecs[1] = '{"bp_idx5",       5, 3, -1, -1, -1,  0, 32'h0,        1'b0, 32, 67};
      vecs[2] = '{"dup_start",    -1, 0, 10, -1, -1,  0, 32'h0,        1'b0, 32, 64};
      vecs[3] = '{"write_r20",    -1, 0, -1, -1, 12, 20, 32'hDEADBEEF, 1'b0, 32, 64};
      vecs[4] = '{"write_r3",     -1, 0, -1, -1,  4,  3, 32'h1,        1'b0, 32, 64};
      vecs[5] = '{"abort_idx7",   -1, 0, -1,  7, -1,  0, 32'h0,        1'b0,  7, -1};
      vecs[6] = '{"restart_sa",    0, 1, -1, -1, -1,  0, 32'h0,        1'b1, 32, 65};
      vecs[7] = '{"bp_last",      31, 2, -1, -1, -1,  0, 32'h0,        1'b0, 32, 66};

      presetRegs();

      // Reset state while rst is held
      #12;
      checkOutput("reset_rd_addr",   64'(rd_addr),   64'(0));
      checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_out_index", 64'(out_index), 64'(0));
      checkOutput("reset_out_data",  64'(out_data),  64'(0));
      checkOutput("reset_out_last",  64'(out_last),  64'(0));
      checkOutput("reset_busy",      64'(busy),      64'(0));
      checkOutput("reset_done",      64'(done),      64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Abort while idle has no effect
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("idle_abort_busy",  64'(busy),      64'(0));
      checkOutput("idle_abort_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      checkOutput("idle_abort_done",  64'(done),      64'(0));

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
      end

      asyncResetSequence();

      // A fresh dump after the reset still runs to completion
      applyStimulus(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32×32-bit register file. On a start pulse it walks register indices 0..NUM_REGS-1 through one register-file read port, captures each value and streams it out as (index, data) words over a valid/ready interface. It sits beside the datapath as a debug and verification channel, driving a read address and consuming read data, the mirror of the write port.

## Interface
- NUM_REGS, 32: registers dumped, indices 0..NUM_REGS-1.
- ADDR_W, 5: register index width; NUM_REGS ≤ 2^ADDR_W.
- DATA_W, 32: register data width.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any busy state.
- rd_addr  out  ADDR_W  register-file read address.
- rd_data  in  DATA_W  register-file read data, combinational from rd_addr.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts word.
- out_index  out  ADDR_W  register index of current word.
- out_data  out  DATA_W  captured register value.
- out_last  out  1  current word is index NUM_REGS-1.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after final word accepted.

## Operation
- States: IDLE, FETCH, SEND.
- IDLE: busy=0, out_valid=0, rd_addr=0. start=1 at an edge: idx←0, busy←1, go to FETCH.
- FETCH: rd_addr=idx. At the next edge, out_data←rd_data, out_index←idx, out_last←(idx==NUM_REGS-1), out_valid←1, go to SEND.
- SEND: out_valid=1. out_index, out_data and out_last stay stable while out_ready=0. Handshake is out_valid&&out_ready at an edge:
  - not last: idx←idx+1, out_valid←0, go to FETCH.
  - last: out_valid←0, busy←0, done←1 for one cycle, go to IDLE.
- abort=1 at any edge while busy: go to IDLE, out_valid←0, busy←0, no done pulse. abort has priority over a simultaneous handshake. abort in IDLE does nothing.
- start while busy is ignored. It is not queued.
- start and abort both high in IDLE: start wins, because abort is only honoured while busy.
- Each word is a snapshot taken at its FETCH edge. A register written before its fetch shows the new value; one written after shows the old value. No global atomicity.
- Register 0 is dumped like any other index.
- idx never exceeds NUM_REGS-1. There is no wrap-around past the last index.

## Timing
- Reset values of all outputs: rd_addr=0, out_valid=0, out_index=0, out_data=0, out_last=0, busy=0, done=0. State=IDLE.
- Asynchronous rst mid-dump clears everything immediately. No done pulse follows.
- Edge E0 samples start, so busy=1 from just after E0. out_valid rises after E1 with index 0.
- Throughput is one word per 2 cycles with out_ready held high. Word k is valid after edge E(2k+1) and accepted at E(2k+2).
- With out_ready=1 throughout, the final handshake is at E(2·NUM_REGS), which is E64 by default. busy falls and done pulses in the cycle after E64.
- Each cycle of out_ready=0 in SEND adds exactly one cycle of latency.
- done is high for exactly one cycle. It is never asserted together with out_valid.

## Test plan
- Preset r[i]=0xA5000000+i (r0=0), start pulse, out_ready=1 → 32 words, out_index 0..31, out_data matches, out_last only on index 31, done exactly 1 cycle after E64, busy high E0..E64.
- Backpressure: hold out_ready=0 for 3 cycles while index 5 is valid → index 5 word is held stable for 3 cycles, no index skipped, done delayed by 3 cycles.
- Second start pulse at index 10 → ignored, and the dump completes exactly once with 32 words.
- Write r20=0xDEADBEEF while index 12 is in SEND → word 20 carries 0xDEADBEEF. Write r3=0x1 after index 3 is accepted → already-sent word 3 is unchanged.
- abort asserted in the same cycle as the index-7 handshake → next cycle out_valid=0, busy=0, no done. A fresh start afterwards restarts from index 0.
- Asynchronous rst asserted mid-cycle during index 15 SEND → all outputs read zero immediately. After release, IDLE is held until start.
